// File: rtl/dostring_pkg.sv
// Shared definitions for the LED-string frame sequencer: transfer type
// encodings, FSM state encodings and the saturating colour-ramp step.
package dostring_pkg;

  // Transfer type presented to the doled driver on input_type
  typedef enum logic [1:0] {
    TYPE_START = 2'd0,
    TYPE_LED   = 2'd1,
    TYPE_END   = 2'd2
  } in_type_e;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_LOAD     = 3'd2,
    ST_STROBE   = 3'd3,
    ST_ACK      = 3'd4,
    ST_NEXT     = 3'd5,
    ST_GAP      = 3'd6
  } state_e;

  // Colour channel count and width
  localparam int NUM_CH = 3;
  localparam int CW     = 8;

  // One ramp step: wrap is decided on the stored value, the increment is
  // summed 10 bits wide and clamped to 255 so it never aliases mod 256.
  function automatic logic [7:0] colour_next(
    input logic [7:0] cur,
    input logic [7:0] step,
    input logic [7:0] idx,
    input logic [7:0] cmax,
    input logic [7:0] crst
  );
    logic [9:0] sum;
    sum = {2'b00, cur} + {2'b00, step} + {2'b00, idx};
    if (cur >= cmax)        colour_next = crst;
    else if (sum > 10'd255) colour_next = 8'hFF;
    else                    colour_next = sum[7:0];
  endfunction

endpackage

// File: rtl/dostring_seq_if.sv
// Sequencer <-> doled driver link. master = sequencer, slave = driver.
// With DOSTRING_BRIGHT_EN defined the link also carries a per-frame
// brightness; without it the driver applies full brightness itself.
interface dostring_seq_if;
  logic       led_start;
  logic [1:0] input_type;
  logic [7:0] red_out;
  logic [7:0] green_out;
  logic [7:0] blue_out;
  logic       doled_busy;
`ifdef DOSTRING_BRIGHT_EN
  logic [4:0] bright_out;

  modport master (
    output led_start, input_type, red_out, green_out, blue_out, bright_out,
    input  doled_busy
  );
  modport slave (
    input  led_start, input_type, red_out, green_out, blue_out, bright_out,
    output doled_busy
  );
`else
  modport master (
    output led_start, input_type, red_out, green_out, blue_out,
    input  doled_busy
  );
  modport slave (
    input  led_start, input_type, red_out, green_out, blue_out,
    output doled_busy
  );
`endif
endinterface

// File: rtl/dostring_ramp.sv
// One colour channel: register plus ramp/wrap update, advanced once per
// LED transfer. The value persists across START/END and across frames.
module dostring_ramp
  import dostring_pkg::*;
#(
  parameter logic [7:0] STEP = 8'd10,
  parameter logic [7:0] CMAX = 8'd200,
  parameter logic [7:0] CRST = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] idx,
  output logic [7:0] value
);

  // Channel register: step on load, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= '0;
    else if (load) value <= colour_next(value, STEP, idx, CMAX, CRST);
  end

endmodule

// File: rtl/dostring_seq.sv
// LED-string frame sequencer: per frame one START, NUM_LEDS LED and one END
// transfer to the doled driver, with carried colour ramps, optional idle gap
// between frames and a completed-frame counter.
// Optional feature: DOSTRING_BRIGHT_EN adds bright_in/bright_out; bright_in
// is captured at the START load and held for the whole frame.
module dostring_seq
  import dostring_pkg::*;
#(
  parameter int NUM_LEDS  = 6,
  parameter int FRAME_GAP = 0,
  parameter int R_STEP    = 10,
  parameter int G_STEP    = 2,
  parameter int B_STEP    = 5,
  parameter int R_MAX     = 200,
  parameter int G_MAX     = 200,
  parameter int B_MAX     = 200,
  parameter int R_RST     = 0,
  parameter int G_RST     = 40,
  parameter int B_RST     = 10
) (
  input  logic                dostring_seq_clk,
  input  logic                dostring_seq_reset_n,
  input  logic                enable,
`ifdef DOSTRING_BRIGHT_EN
  input  logic [4:0]          bright_in,
`endif
  dostring_seq_if.master      bus,
  output logic                frame_done,
  output logic [15:0]         frame_count
);

  localparam logic [7:0]  LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [15:0] GAP_LAST = (FRAME_GAP > 0) ? 16'(FRAME_GAP - 1) : 16'd0;

  // Per-channel ramp settings, index 0 = red, 1 = green, 2 = blue
  localparam logic [NUM_CH-1:0][CW-1:0] STEP_V = {8'(B_STEP), 8'(G_STEP), 8'(R_STEP)};
  localparam logic [NUM_CH-1:0][CW-1:0] MAX_V  = {8'(B_MAX),  8'(G_MAX),  8'(R_MAX)};
  localparam logic [NUM_CH-1:0][CW-1:0] RST_V  = {8'(B_RST),  8'(G_RST),  8'(R_RST)};

  state_e     state, state_n;
  in_type_e   phase, phase_n;
  logic [7:0] idx, idx_n;
  logic [15:0] gap_cnt, gap_n;
  logic       start_q, start_n;
  logic       done_n;
  logic       type_load;
  logic       colour_load;
  logic       count_inc;
  logic [1:0] type_q;
  logic [NUM_CH-1:0][CW-1:0] colour;

  // State, phase, LED index and gap counter registers
  always_ff @(posedge dostring_seq_clk or negedge dostring_seq_reset_n) begin
    if (!dostring_seq_reset_n) begin
      state   <= ST_IDLE;
      phase   <= TYPE_START;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      idx     <= idx_n;
      gap_cnt <= gap_n;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    idx_n       = idx;
    gap_n       = gap_cnt;
    start_n     = start_q;
    done_n      = 1'b0;
    type_load   = 1'b0;
    colour_load = 1'b0;
    count_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_WAIT_RDY;
          phase_n = TYPE_START;
        end
      end
      ST_WAIT_RDY: begin
        if (!bus.doled_busy) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        // only place data outputs move; the driver is idle here
        type_load   = 1'b1;
        colour_load = (phase == TYPE_LED);
        state_n     = ST_STROBE;
      end
      ST_STROBE: begin
        start_n = 1'b1;
        state_n = ST_ACK;
      end
      ST_ACK: begin
        // keep requesting until the driver shows it took the transfer
        if (bus.doled_busy) begin
          start_n = 1'b0;
          state_n = ST_NEXT;
        end
      end
      ST_NEXT: begin
        case (phase)
          TYPE_START: begin
            phase_n = TYPE_LED;
            idx_n   = '0;
            state_n = ST_WAIT_RDY;
          end
          TYPE_LED: begin
            if (idx == LAST_IDX) phase_n = TYPE_END;
            else                 idx_n   = idx + 8'd1;
            state_n = ST_WAIT_RDY;
          end
          default: begin
            // END acknowledged: frame complete; enable only consulted here
            done_n    = 1'b1;
            count_inc = 1'b1;
            phase_n   = TYPE_START;
            gap_n     = '0;
            if (FRAME_GAP != 0) state_n = ST_GAP;
            else if (enable)    state_n = ST_WAIT_RDY;
            else                state_n = ST_IDLE;
          end
        endcase
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = ST_IDLE;
        else                     gap_n   = gap_cnt + 16'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered handshake, type, frame pulse and frame counter
  always_ff @(posedge dostring_seq_clk or negedge dostring_seq_reset_n) begin
    if (!dostring_seq_reset_n) begin
      start_q     <= 1'b0;
      type_q      <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      start_q    <= start_n;
      frame_done <= done_n;
      if (type_load) type_q      <= phase;
      if (count_inc) frame_count <= frame_count + 16'd1;
    end
  end

  // Colour ramps, one lane per channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dostring_ramp #(
      .STEP (STEP_V[c]),
      .CMAX (MAX_V[c]),
      .CRST (RST_V[c])
    ) u_ramp (
      .clk   (dostring_seq_clk),
      .rst_n (dostring_seq_reset_n),
      .load  (colour_load),
      .idx   (idx),
      .value (colour[c])
    );
  end

  assign bus.led_start  = start_q;
  assign bus.input_type = type_q;
  assign bus.red_out    = colour[0];
  assign bus.green_out  = colour[1];
  assign bus.blue_out   = colour[2];

`ifdef DOSTRING_BRIGHT_EN
  logic [4:0] bright_q;

  // Frame brightness: captured with the START transfer, held to END
  always_ff @(posedge dostring_seq_clk or negedge dostring_seq_reset_n) begin
    if (!dostring_seq_reset_n)
      bright_q <= '0;
    else if (state == ST_LOAD && phase == TYPE_START)
      bright_q <= bright_in;
  end

  assign bus.bright_out = bright_q;
`else
  // No brightness on the link; the driver runs at full brightness (5'h1F).
`endif

endmodule

// File: tb/tb_dostring_seq.sv
// Directed bench for dostring_seq: two instances (defaults, and a 4-LED
// variant with gap/wrap/saturation settings), each with a doled model that
// raises busy the clock after it sees led_start and keeps it for 8 clocks.
`timescale 1ns/1ps
module tb_dostring_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0, rst1 = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic fd0, fd1;
  logic [15:0] fc0, fc1;
`ifdef DOSTRING_BRIGHT_EN
  logic [4:0] bri0 = 5'd0, bri1 = 5'd0;
`endif

  int checks = 0;
  int passed = 0;

  dostring_seq_if bus0 ();
  dostring_seq_if bus1 ();

  dostring_seq u0 (
    .dostring_seq_clk     (clk),
    .dostring_seq_reset_n (rst0),
    .enable               (en0),
`ifdef DOSTRING_BRIGHT_EN
    .bright_in            (bri0),
`endif
    .bus                  (bus0),
    .frame_done           (fd0),
    .frame_count          (fc0)
  );

  dostring_seq #(
    .NUM_LEDS  (4),
    .FRAME_GAP (10),
    .B_MAX     (20),
    .G_STEP    (250),
    .G_MAX     (255)
  ) u1 (
    .dostring_seq_clk     (clk),
    .dostring_seq_reset_n (rst1),
    .enable               (en1),
`ifdef DOSTRING_BRIGHT_EN
    .bright_in            (bri1),
`endif
    .bus                  (bus1),
    .frame_done           (fd1),
    .frame_count          (fc1)
  );

  // Transfer logs, one entry per accepted transfer
  logic [1:0] t0 [64];
  logic [7:0] r0 [64], g0 [64], b0 [64];
  logic [1:0] t1 [64];
  logic [7:0] g1 [64], b1 [64];
`ifdef DOSTRING_BRIGHT_EN
  logic [4:0] br0 [64];
`endif
  int n0 = 0, n1 = 0;
  int cnt0 = 0, cnt1 = 0;

  // Driver model 0
  always @(posedge clk or negedge rst0) begin
    if (!rst0) begin
      cnt0 <= 0;
      bus0.doled_busy <= 1'b0;
    end else if (cnt0 != 0) begin
      cnt0 <= cnt0 - 1;
      bus0.doled_busy <= (cnt0 > 1);
    end else if (bus0.led_start) begin
      cnt0 <= 8;
      bus0.doled_busy <= 1'b1;
      if (n0 < 64) begin
        t0[n0] <= bus0.input_type;
        r0[n0] <= bus0.red_out;
        g0[n0] <= bus0.green_out;
        b0[n0] <= bus0.blue_out;
`ifdef DOSTRING_BRIGHT_EN
        br0[n0] <= bus0.bright_out;
`endif
        n0 <= n0 + 1;
      end
    end
  end

  // Driver model 1
  always @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      cnt1 <= 0;
      bus1.doled_busy <= 1'b0;
    end else if (cnt1 != 0) begin
      cnt1 <= cnt1 - 1;
      bus1.doled_busy <= (cnt1 > 1);
    end else if (bus1.led_start) begin
      cnt1 <= 8;
      bus1.doled_busy <= 1'b1;
      if (n1 < 64) begin
        t1[n1] <= bus1.input_type;
        g1[n1] <= bus1.green_out;
        b1[n1] <= bus1.blue_out;
        n1 <= n1 + 1;
      end
    end
  end

  // Data-stability monitors: data must not move while busy is high
  logic [25:0] d0, d1, p0, p1;
  logic pv0 = 1'b0, pv1 = 1'b0;
  int viol0 = 0, viol1 = 0;
  assign d0 = {bus0.input_type, bus0.red_out, bus0.green_out, bus0.blue_out};
  assign d1 = {bus1.input_type, bus1.red_out, bus1.green_out, bus1.blue_out};

  always @(negedge clk) begin
    if (!rst0) pv0 = 1'b0;
    else begin
      if (pv0 && bus0.doled_busy && d0 !== p0) viol0++;
      p0 = d0; pv0 = 1'b1;
    end
    if (!rst1) pv1 = 1'b0;
    else begin
      if (pv1 && bus1.doled_busy && d1 !== p1) viol1++;
      p1 = d1; pv1 = 1'b1;
    end
  end

  localparam logic [1:0] ET [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
  localparam logic [7:0] ER [6] = '{8'd10, 8'd21, 8'd33, 8'd46, 8'd60, 8'd75};
  localparam logic [7:0] EG [6] = '{8'd2, 8'd5, 8'd9, 8'd14, 8'd20, 8'd27};
  localparam logic [7:0] EB [6] = '{8'd5, 8'd11, 8'd18, 8'd26, 8'd35, 8'd45};
  localparam logic [7:0] EB1 [4] = '{8'd5, 8'd11, 8'd18, 8'd26};
  localparam logic [7:0] EG1 [4] = '{8'd250, 8'd255, 8'd40, 8'd255};

  task automatic wait_fd0(input string nm);
    int k = 0;
    while (fd0 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (k >= 400) $display("FAIL %s: frame_done not seen within %0d clocks", nm, k);
    else passed++;
  endtask

  task automatic wait_n0(input int target, input string nm);
    int k = 0;
    while (n0 < target && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (k >= 400) $display("FAIL %s: transfer count %0d, required %0d", nm, n0, target);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.led_start, d0, fd0, fc0} !== '0)
      $display("FAIL reset_u0: got start=%b data=%h fd=%b fc=%0d want all 0",
               bus0.led_start, d0, fd0, fc0);
    else passed++;
    checks++;
    if ({bus1.led_start, d1, fd1, fc1} !== '0)
      $display("FAIL reset_u1: got start=%b data=%h fd=%b fc=%0d want all 0",
               bus1.led_start, d1, fd1, fc1);
    else passed++;
  endtask

  task automatic test_default_frame();
    en0 = 1'b1;
    rst0 = 1'b1;
    wait_fd0("first_frame");
    checks++;
    if (n0 !== 8) $display("FAIL frame1_len: got %0d want 8", n0); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (t0[i] !== ET[i]) $display("FAIL type[%0d]: got %0d want %0d", i, t0[i], ET[i]);
      else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({r0[i+1], g0[i+1], b0[i+1]} !== {ER[i], EG[i], EB[i]})
        $display("FAIL led%0d_rgb: got %0d,%0d,%0d want %0d,%0d,%0d", i,
                 r0[i+1], g0[i+1], b0[i+1], ER[i], EG[i], EB[i]);
      else passed++;
    end
    checks++;
    if (b0[7] !== 8'd45) $display("FAIL end_holds_blue: got %0d want 45", b0[7]); else passed++;
    checks++;
    if (fc0 !== 16'd1) $display("FAIL frame_count1: got %0d want 1", fc0); else passed++;
    @(negedge clk);
    checks++;
    if (fd0 !== 1'b0) $display("FAIL frame_done_pulse: got %b want 0", fd0); else passed++;
  endtask

  task automatic test_enable_drop();
    wait_n0(11, "frame2_led1");
    en0 = 1'b0;
    wait_fd0("frame2_done");
    checks++;
    if (n0 !== 16) $display("FAIL drop_len: got %0d want 16", n0); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (t0[8+i] !== ET[i]) $display("FAIL drop_type[%0d]: got %0d want %0d", i, t0[8+i], ET[i]);
      else passed++;
    end
    checks++;
    if (b0[9] !== 8'd50) $display("FAIL carry_blue: got %0d want 50", b0[9]); else passed++;
    repeat (60) @(negedge clk);
    checks++;
    if (n0 !== 16 || fc0 !== 16'd2)
      $display("FAIL idle_after_drop: got n=%0d fc=%0d want 16,2", n0, fc0);
    else passed++;
  endtask

  task automatic test_reset_mid_transfer();
    int k = 0;
    int base;
    en0 = 1'b1;
    while (!(bus0.led_start === 1'b1 && bus0.doled_busy === 1'b0) && k < 100) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 100) $display("FAIL reach_ack: led_start not seen in %0d clocks", k); else passed++;
    base = n0;
    rst0 = 1'b0;
    #1;
    checks++;
    if ({bus0.led_start, d0, fd0, fc0} !== '0)
      $display("FAIL async_reset: got start=%b data=%h fc=%0d want all 0", bus0.led_start, d0, fc0);
    else passed++;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    wait_n0(base + 2, "restart");
    en0 = 1'b0;
    checks++;
    if ({t0[base], t0[base+1], b0[base+1], g0[base+1], r0[base+1]} !==
        {2'd0, 2'd1, 8'd5, 8'd2, 8'd10})
      $display("FAIL restart_seq: got types %0d,%0d rgb %0d,%0d,%0d want 0,1 10,2,5",
               t0[base], t0[base+1], r0[base+1], g0[base+1], b0[base+1]);
    else passed++;
    wait_fd0("restart_done");
    checks++;
    if (fc0 !== 16'd1) $display("FAIL count_after_reset: got %0d want 1", fc0); else passed++;
  endtask

  task automatic test_ramp_wrap();
    int k = 0;
    en1 = 1'b1;
    rst1 = 1'b1;
    while (fd1 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (k >= 400) $display("FAIL u1_frame1: frame_done not seen"); else passed++;
    checks++;
    if (n1 !== 6 || t1[5] !== 2'd2) $display("FAIL u1_len: got n=%0d last=%0d want 6,2", n1, t1[5]);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b1[i+1] !== EB1[i]) $display("FAIL ramp_blue[%0d]: got %0d want %0d", i, b1[i+1], EB1[i]);
      else passed++;
    end
  endtask

  // Entered on the frame_done clock: 10 gap clocks, then IDLE, WAIT_RDY,
  // LOAD, STROBE before led_start is visible.
  task automatic test_frame_gap();
    int k = 0;
    while (bus1.led_start !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (k !== 14) $display("FAIL frame_gap: led_start after %0d clocks want 14", k); else passed++;
  endtask

  task automatic test_saturation();
    int k = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g1[i+1] !== EG1[i]) $display("FAIL sat_green[%0d]: got %0d want %0d", i, g1[i+1], EG1[i]);
      else passed++;
    end
    while (n1 < 8 && k < 200) begin @(negedge clk); k++; end
    en1 = 1'b0;
    checks++;
    if (b1[7] !== 8'd10) $display("FAIL ramp_5th_blue: got %0d want 10", b1[7]); else passed++;
    checks++;
    if (g1[7] !== 8'd40) $display("FAIL sat_wrap_green: got %0d want 40", g1[7]); else passed++;
  endtask

`ifdef DOSTRING_BRIGHT_EN
  task automatic test_bright();
    int base = n0;
    bri0 = 5'd31;
    en0 = 1'b1;
    wait_n0(base + 3, "bright_led1");
    bri0 = 5'd3;
    wait_n0(base + 9, "bright_next");
    en0 = 1'b0;
    checks++;
    if (br0[base+7] !== 5'd31) $display("FAIL bright_hold: got %0d want 31", br0[base+7]); else passed++;
    checks++;
    if (br0[base+8] !== 5'd3) $display("FAIL bright_next: got %0d want 3", br0[base+8]); else passed++;
    wait_fd0("bright_done");
  endtask
`endif

  task automatic test_protocol();
    checks++;
    if (viol0 !== 0) $display("FAIL stable_u0: got %0d changes while busy want 0", viol0); else passed++;
    checks++;
    if (viol1 !== 0) $display("FAIL stable_u1: got %0d changes while busy want 0", viol1); else passed++;
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_enable_drop();
    test_reset_mid_transfer();
    test_ramp_wrap();
    test_frame_gap();
    test_saturation();
`ifdef DOSTRING_BRIGHT_EN
    test_bright();
`endif
    repeat (20) @(negedge clk);
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
